// File: rtl/i2s_sound_out.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : i2s_sound_out
// Purpose  : I2S output stage for the synth mixer. A one-deep holding register
//            captures the signed left/right frame sums on a single-cycle strobe.
//            Each frame is then sent as standard I2S: left slot first, with the
//            MSB one BCLK after the LRCK edge. BCLK and LRCK are derived from the
//            single audio clock. Sticky flags report underrun and overrun.
// Ports    : sCLK_AUDIO  in  single clock, all logic on its rising edge
//            iRST_N      in  asynchronous active-low reset
//            lsound_in   in  signed left sample  [DATA_WIDTH-1:0]
//            rsound_in   in  signed right sample [DATA_WIDTH-1:0]
//            sample_stb  in  1-cycle pulse, lsound_in/rsound_in valid
//            mute        in  1 = frames loaded from now on carry zeros
//            clr_flags   in  clears the sticky flags
//            oBCLK       out I2S bit clock
//            oLRCK       out I2S word select, 0 = left slot
//            oDATA       out I2S serial data, changes on BCLK falling edge
//            frame_start out 1-cycle pulse when a frame enters the shifters
//            underrun    out sticky: a frame was loaded with no new sample
//            overrun     out sticky: a held sample was overwritten before load
// Revision : 1.0  initial release
// ============================================================================
module i2s_sound_out #(
  parameter int DATA_WIDTH = 24,  // sample width (16 for 16-bit builds)
  parameter int SLOT_WIDTH = 32,  // BCLK periods per slot, >= DATA_WIDTH+1
  parameter int BCLK_DIV   = 4    // clocks per BCLK half-period, >= 2
) (
  input  logic                  sCLK_AUDIO,
  input  logic                  iRST_N,
  input  logic [DATA_WIDTH-1:0] lsound_in,
  input  logic [DATA_WIDTH-1:0] rsound_in,
  input  logic                  sample_stb,
  input  logic                  mute,
  input  logic                  clr_flags,
  output logic                  oBCLK,
  output logic                  oLRCK,
  output logic                  oDATA,
  output logic                  frame_start,
  output logic                  underrun,
  output logic                  overrun
);

  localparam int CNT_W = $clog2(2 * SLOT_WIDTH);
  localparam int DIV_W = $clog2(BCLK_DIV);

  localparam logic [DIV_W-1:0] c_div_last = DIV_W'(BCLK_DIV - 1);
  localparam logic [CNT_W-1:0] c_bit_last = CNT_W'(2 * SLOT_WIDTH - 1);
  localparam logic [CNT_W-1:0] c_slot     = CNT_W'(SLOT_WIDTH);

  logic [DIV_W-1:0]      div_cnt_q,     div_cnt_d;
  logic                  bclk_q,        bclk_d;
  logic [CNT_W-1:0]      bit_cnt_q,     bit_cnt_d;
  logic                  lrck_q,        lrck_d;
  logic                  data_q,        data_d;
  logic                  frame_start_q, frame_start_d;
  logic                  underrun_q,    underrun_d;
  logic                  overrun_q,     overrun_d;
  logic                  fresh_q,       fresh_d;
  logic [DATA_WIDTH-1:0] hold_l_q,      hold_l_d;
  logic [DATA_WIDTH-1:0] hold_r_q,      hold_r_d;
  logic [DATA_WIDTH-1:0] shift_l_q,     shift_l_d;
  logic [DATA_WIDTH-1:0] shift_r_q,     shift_r_d;

  logic                  w_fall;      // this cycle drives BCLK 1->0
  logic                  w_load;      // this fall starts a new frame
  logic [CNT_W-1:0]      w_k;         // bit position inside the current slot
  logic [DATA_WIDTH-1:0] w_slot;      // sample owning the current slot
  logic                  w_set_under;
  logic                  w_set_over;

  always_comb begin
    // Bit-clock divider: BCLK toggles each time the counter wraps.
    div_cnt_d = div_cnt_q + DIV_W'(1);
    bclk_d    = bclk_q;
    w_fall    = 1'b0;
    if (div_cnt_q == c_div_last) begin
      div_cnt_d = '0;
      bclk_d    = ~bclk_q;
      w_fall    = bclk_q;
    end

    bit_cnt_d     = bit_cnt_q;
    lrck_d        = lrck_q;
    data_d        = data_q;
    frame_start_d = 1'b0;
    shift_l_d     = shift_l_q;
    shift_r_d     = shift_r_q;
    w_load        = 1'b0;
    w_k           = '0;
    w_slot        = shift_l_q;

    // Everything serial moves on the BCLK falling edge, so the codec sees
    // stable LRCK/DATA on its rising-edge sample point.
    if (w_fall) begin
      bit_cnt_d = (bit_cnt_q == c_bit_last) ? '0 : bit_cnt_q + CNT_W'(1);
      lrck_d    = (bit_cnt_d >= c_slot);
      w_load    = (bit_cnt_d == '0);
      w_k       = lrck_d ? (bit_cnt_d - c_slot) : bit_cnt_d;
      w_slot    = lrck_d ? shift_r_q : shift_l_q;
      // Position 0 is the one-BCLK I2S delay; positions past the sample
      // width are zero padding.
      data_d = 1'b0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
        if (int'(w_k) == DATA_WIDTH - i) begin
          data_d = w_slot[i];
        end
      end
    end

    if (w_load) begin
      shift_l_d     = mute ? '0 : hold_l_q;
      shift_r_d     = mute ? '0 : hold_r_q;
      frame_start_d = 1'b1;
    end

    // Capture: the load above always reads the previous hold value, so a
    // strobe coinciding with a load is kept for the following frame.
    hold_l_d = sample_stb ? lsound_in : hold_l_q;
    hold_r_d = sample_stb ? rsound_in : hold_r_q;
    fresh_d  = fresh_q;
    if (w_load) begin
      fresh_d = 1'b0;
    end
    if (sample_stb) begin
      fresh_d = 1'b1;
    end

    w_set_under = w_load && !fresh_q;
    w_set_over  = sample_stb && fresh_q && !w_load;

    // A flag event in the same cycle as a clear takes priority.
    underrun_d = w_set_under ? 1'b1 : (clr_flags ? 1'b0 : underrun_q);
    overrun_d  = w_set_over  ? 1'b1 : (clr_flags ? 1'b0 : overrun_q);
  end

  always_ff @(posedge sCLK_AUDIO or negedge iRST_N) begin
    if (!iRST_N) begin
      div_cnt_q     <= '0;
      bclk_q        <= 1'b0;
      bit_cnt_q     <= c_bit_last;  // first fall wraps to 0 and loads a frame
      lrck_q        <= 1'b0;
      data_q        <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
      overrun_q     <= 1'b0;
      fresh_q       <= 1'b0;
      hold_l_q      <= '0;
      hold_r_q      <= '0;
      shift_l_q     <= '0;
      shift_r_q     <= '0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      bclk_q        <= bclk_d;
      bit_cnt_q     <= bit_cnt_d;
      lrck_q        <= lrck_d;
      data_q        <= data_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
      overrun_q     <= overrun_d;
      fresh_q       <= fresh_d;
      hold_l_q      <= hold_l_d;
      hold_r_q      <= hold_r_d;
      shift_l_q     <= shift_l_d;
      shift_r_q     <= shift_r_d;
    end
  end

  assign oBCLK       = bclk_q;
  assign oLRCK       = lrck_q;
  assign oDATA       = data_q;
  assign frame_start = frame_start_q;
  assign underrun    = underrun_q;
  assign overrun     = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_i2s_sound_out.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_i2s_sound_out
// Purpose  : Self-checking bench for i2s_sound_out. A reference model built
//            from frame arithmetic (cycle index since reset) predicts flags,
//            BCLK/LRCK and the frame contents. Each predicted frame is queued
//            and a monitor deserialises the I2S stream on BCLK rising edges,
//            then compares it against the queued frame.
// Revision : 1.0  initial release
// ============================================================================
module tb_i2s_sound_out;

  localparam int DW    = 24;
  localparam int SW    = 32;
  localparam int BD    = 4;
  localparam int FRAME = 2 * SW * 2 * BD;   // clocks per frame
  localparam int FIRST = 2 * BD;            // first load, clocks after release

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] l_in = '0;
  logic [DW-1:0] r_in = '0;
  logic          stb = 1'b0;
  logic          mute = 1'b0;
  logic          clr = 1'b0;
  logic          o_bclk, o_lrck, o_data, o_fs, o_under, o_over;

  always #5 clk = ~clk;

  i2s_sound_out #(.DATA_WIDTH(DW), .SLOT_WIDTH(SW), .BCLK_DIV(BD)) dut (
    .sCLK_AUDIO (clk),
    .iRST_N     (rst_n),
    .lsound_in  (l_in),
    .rsound_in  (r_in),
    .sample_stb (stb),
    .mute       (mute),
    .clr_flags  (clr),
    .oBCLK      (o_bclk),
    .oLRCK      (o_lrck),
    .oDATA      (o_data),
    .frame_start(o_fs),
    .underrun   (o_under),
    .overrun    (o_over)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int            t;
    logic [DW-1:0] l;
    logic [DW-1:0] r;
  } frame_t;

  frame_t        sb_q[$];
  int            m_t;          // rising edges since reset release
  logic [DW-1:0] m_hold_l, m_hold_r;
  logic          m_fresh, m_under, m_over;
  logic          m_load, m_su, m_so;
  frame_t        m_e;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t = 0; m_hold_l = '0; m_hold_r = '0;
      m_fresh = 1'b0; m_under = 1'b0; m_over = 1'b0;
      sb_q.delete();
    end else begin
      m_t++;
      // A frame starts every FRAME clocks, the first FIRST clocks after release.
      m_load = (m_t >= FIRST) && ((m_t - FIRST) % FRAME == 0);
      m_su   = m_load && !m_fresh;
      m_so   = stb && m_fresh && !m_load;
      if (m_load) begin
        m_e.t = m_t;
        m_e.l = mute ? '0 : m_hold_l;
        m_e.r = mute ? '0 : m_hold_r;
        sb_q.push_back(m_e);
        m_fresh = 1'b0;
      end
      if (stb) begin
        m_hold_l = l_in; m_hold_r = r_in; m_fresh = 1'b1;
      end
      m_under = m_su ? 1'b1 : (clr ? 1'b0 : m_under);
      m_over  = m_so ? 1'b1 : (clr ? 1'b0 : m_over);
    end
  end

  function automatic logic exp_bclk(input int t);
    return ((t / BD) % 2) == 1;
  endfunction

  function automatic logic exp_lrck(input int t);
    if (t < FIRST) return 1'b0;
    return (((t / (2 * BD)) - 1) % (2 * SW)) >= SW;
  endfunction

  // Per-cycle clock and flag checks, away from the active edge.
  always @(negedge clk) begin
    check("bclk",     64'(o_bclk),  64'(exp_bclk(m_t)));
    check("lrck",     64'(o_lrck),  64'(exp_lrck(m_t)));
    check("underrun", 64'(o_under), 64'(m_under));
    check("overrun",  64'(o_over),  64'(m_over));
  end

  // ---------------- monitor ----------------
  logic        mon_active = 1'b0;
  logic        mon_prev   = 1'b0;
  int          mon_pos    = 0;
  logic [63:0] mon_data, mon_lr;
  frame_t      mon_e;

  task automatic finish_frame();
    logic [63:0]   ed, el;
    logic [DW-1:0] s;
    int            k;
    for (int p = 0; p < 2 * SW; p++) begin
      k     = p % SW;
      s     = (p < SW) ? mon_e.l : mon_e.r;
      ed[p] = (k >= 1 && k <= DW) ? s[DW-k] : 1'b0;
      el[p] = (p >= SW);
    end
    check("frame_len",  64'(mon_pos), 64'(2 * SW));
    check("frame_data", mon_data, ed);
    check("frame_lrck", mon_lr, el);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_active = 1'b0;
      mon_prev   = 1'b0;
    end else begin
      if (o_bclk && !mon_prev && mon_active) begin
        if (mon_pos < 2 * SW) begin
          mon_data[mon_pos] = o_data;
          mon_lr[mon_pos]   = o_lrck;
        end
        mon_pos++;
      end
      mon_prev = o_bclk;
      if (o_fs) begin
        if (mon_active) finish_frame();
        check("frame_expected", 64'(sb_q.size() > 0), 64'(1));
        if (sb_q.size() > 0) begin
          mon_e = sb_q.pop_front();
          check("frame_time", 64'(m_t), 64'(mon_e.t));
          mon_active = 1'b1;
          mon_pos    = 0;
          mon_data   = '0;
          mon_lr     = '0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Position just after edge T-1 so inputs driven now are sampled at edge T.
  task automatic at_edge(input int T);
    int g = 0;
    while (m_t != T - 1 && g < 4000) begin
      tick();
      g++;
    end
    if (m_t != T - 1) check("wait_bound", 64'(m_t), 64'(T - 1));
  endtask

  function automatic int next_load(input int t);
    if (t < FIRST) return FIRST;
    return FIRST + ((t - FIRST) / FRAME + 1) * FRAME;
  endfunction

  task automatic pulse_stb(input logic [DW-1:0] l, input logic [DW-1:0] r);
    l_in = l; r_in = r; stb = 1'b1;
    tick();
    stb = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  int L;

  initial begin
    // Reset state
    repeat (3) tick();
    check("reset_outputs", 64'({o_bclk, o_lrck, o_data, o_fs, o_under, o_over}), 64'(0));
    rst_n = 1'b1;

    // S1: no strobe; first frame all zeros, underrun after first load
    at_edge(FIRST + 12);
    check("s1_underrun", 64'(o_under), 64'(1));
    at_edge(FIRST + FRAME + 10);
    pulse_clr();

    // S2: known pattern 800001 / 7FFFFF
    L = next_load(m_t);
    at_edge(L - 200);
    pulse_stb(24'h800001, 24'h7FFFFF);
    check("s2_overrun", 64'(o_over), 64'(0));
    at_edge(L + FRAME + 5);

    // S3: two strobes within one frame, then clear
    L = next_load(m_t);
    at_edge(L + 5);
    pulse_stb(24'h123456, 24'hABCDEF);
    repeat (20) tick();
    pulse_stb(24'h5A5A5A, 24'hC3C3C3);
    check("s3_overrun_set", 64'(o_over), 64'(1));
    pulse_clr();
    check("s3_overrun_clr", 64'(o_over), 64'(0));
    at_edge(next_load(m_t) + FRAME + 5);

    // S4: strobe on the exact load edge
    L = next_load(m_t);
    at_edge(L - 100);
    clr = 1'b1;
    pulse_stb(24'h0F0F0F, 24'hF0F0F0);
    clr = 1'b0;
    at_edge(L);
    pulse_stb(24'h3C3C3C, 24'h00FF00);
    check("s4_overrun",  64'(o_over),  64'(0));
    check("s4_underrun", 64'(o_under), 64'(0));
    at_edge(L + FRAME + 5);
    check("s4_no_underrun", 64'(o_under), 64'(0));

    // S5: mute at load with valid sample
    L = next_load(m_t);
    at_edge(L - 50);
    clr = 1'b1;
    pulse_stb(24'h7E7E7E, 24'h818181);
    clr = 1'b0;
    at_edge(L);
    mute = 1'b1;
    tick();
    mute = 1'b0;
    check("s5_no_underrun", 64'(o_under), 64'(0));
    at_edge(L + FRAME + 5);
    check("s5_underrun_next", 64'(o_under), 64'(1));

    // S6: reset in the middle of the right slot
    L = next_load(m_t);
    at_edge(L + (FRAME * 3) / 4);
    pulse_stb(24'h111111, 24'h222222);
    rst_n = 1'b0;
    #1;
    check("s6_reset_outputs", 64'({o_bclk, o_lrck, o_data, o_fs, o_under, o_over}), 64'(0));
    repeat (5) tick();
    rst_n = 1'b1;
    at_edge(FIRST + 12);
    check("s6_underrun", 64'(o_under), 64'(1));
    at_edge(FIRST + 2 * FRAME + 5);

    // S7: randomized strobes, clears and mute
    for (int c = 0; c < 10000; c++) begin
      stb = ($urandom_range(0, 449) == 0);
      if (stb) begin
        l_in = DW'($urandom);
        r_in = DW'($urandom);
      end
      clr = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 999) == 0) mute = ~mute;
      tick();
    end
    stb = 1'b0; clr = 1'b0; mute = 1'b0;

    // Let the last complete frame be evaluated
    at_edge(next_load(m_t) + 2);
    check("sb_drain", 64'(sb_q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got %0d checks, expected completion", n_checks);
    $fatal(1);
  end

endmodule
`default_nettype wire
